// File: rtl/pe_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// pe_muldiv_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - op encodings (op[0] = unsigned, op[1] = divide / subtract, op[2] = accumulate)
//   - FSM state encoding
//   - MUL_STAGES_MAX, upper bound of the multiplier pipeline depth
// Optional feature macro: MULDIV_ACC_EN (adds the ACC state for madd/msub).
// -----------------------------------------------------------------------------
package pe_muldiv_pkg;

    localparam int MUL_STAGES_MAX = 4;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MSUB  = 3'b110,
        OP_MSUBU = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
`ifdef MULDIV_ACC_EN
        ST_ACC      = 3'd2,
`endif
        ST_DIV_PREP = 3'd3,
        ST_DIV_ITER = 3'd4,
        ST_DIV_FIX  = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

endpackage

// File: rtl/muldiv_divider.sv
// -----------------------------------------------------------------------------
// muldiv_divider
// Unsigned restoring radix-2 divider, one quotient bit per clock.
// The first iteration is performed on the i_start edge itself, so the result
// is valid (o_done=1) XLEN cycles after i_start. o_done stays high until the
// next i_start or i_abort. Requires XLEN >= 2.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_start          load operands and run the first iteration
//   i_abort          stop and discard the current division
//   i_dividend       unsigned dividend
//   i_divisor        unsigned divisor (non-zero; zero is handled by the caller)
//   o_quotient       quotient, valid while o_done
//   o_remainder      remainder, valid while o_done
//   o_done           result valid
// -----------------------------------------------------------------------------
module muldiv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_done
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // One restoring step, fed either by fresh operands (start) or by the
    // running partial results.
    logic [XLEN-1:0] w_src_rem;
    logic [XLEN-1:0] w_src_quo;
    logic [XLEN-1:0] w_src_div;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;

    assign w_src_rem  = i_start ? '0         : r_rem;
    assign w_src_quo  = i_start ? i_dividend : r_quo;
    assign w_src_div  = i_start ? i_divisor  : r_div;
    assign w_trial    = {w_src_rem, w_src_quo[XLEN-1]};
    assign w_diff     = w_trial - {1'b0, w_src_div};
    // Partial remainder is always below the divisor, so the difference fits
    // in XLEN+1 bits and its MSB is a clean borrow flag.
    assign w_ge       = ~w_diff[XLEN];
    assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_quo_next = {w_src_quo[XLEN-2:0], w_ge};

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_div  <= i_divisor;
            r_cnt  <= CNT_W'(XLEN - 1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = r_done;

endmodule

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv
// Multi-cycle multiply/divide unit for the execute stage. One HI/LO-producing
// operation at a time; result returned as {HI,LO} with a done/hold handshake.
// Optional feature macro: MULDIV_ACC_EN
//   defined   : madd/maddu/msub/msubu accumulate into hi_lo_in (ACC state)
//   undefined : ops 1xx complete in one cycle returning hi_lo_in unchanged
// Parameters:
//   XLEN        operand width (>= 2)
//   MUL_STAGES  multiplier latency in cycles (1..MUL_STAGES_MAX)
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                launch request (only honoured in IDLE)
//   op                   operation code (see pe_muldiv_pkg::op_e)
//   opreat_A, opreat_B   rs / rt operands
//   hi_lo_in             current {HI,LO}, captured at start
//   is_busbusy           downstream hold, keeps the result presented
//   flush                abort current operation, no result
//   busy                 unit not idle
//   opreat_over          result valid
//   hi_value, lo_value   result
// -----------------------------------------------------------------------------
module ex_muldiv
    import pe_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   opreat_A,
    input  logic [XLEN-1:0]   opreat_B,
    input  logic [2*XLEN-1:0] hi_lo_in,
    input  logic              is_busbusy,
    input  logic              flush,
    output logic              busy,
    output logic              opreat_over,
    output logic [XLEN-1:0]   hi_value,
    output logic [XLEN-1:0]   lo_value
);

    localparam int MCNT_W = $clog2(MUL_STAGES_MAX) + 1;

    state_e r_state;
    state_e w_next_state;

    logic                r_unsigned;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_result;
    logic [MCNT_W-1:0]   r_mul_cnt;
    logic                r_q_neg;
    logic                r_r_neg;
    logic [2*XLEN-1:0]   r_mul_pipe [MUL_STAGES];
`ifdef MULDIV_ACC_EN
    logic                r_acc;
    logic                r_sub;
    logic [2*XLEN-1:0]   r_hilo_in;
`endif

    logic                w_accept;
    logic                w_mul_last;
    logic [2*XLEN-1:0]   w_mul_a;
    logic [2*XLEN-1:0]   w_mul_b;
    logic [2*XLEN-1:0]   w_product;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_by_zero;
    logic                w_div_start;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic                w_div_done;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;

    assign w_accept   = (r_state == ST_IDLE) && start && !flush;
    assign w_mul_last = (r_mul_cnt == MCNT_W'(MUL_STAGES - 1));

    // ------------------------------------------------------------------
    // Multiplier: operands are extended to 2*XLEN (sign or zero per op[0])
    // so the truncated product is the exact two's-complement result. The
    // product of the launching operands enters the pipe on the start edge;
    // the trailing registers give the synthesis tool room to retime it.
    // ------------------------------------------------------------------
    assign w_mul_a   = {{XLEN{~op[0] & opreat_A[XLEN-1]}}, opreat_A};
    assign w_mul_b   = {{XLEN{~op[0] & opreat_B[XLEN-1]}}, opreat_B};
    assign w_product = w_mul_a * w_mul_b;

    // NOTE: the pipeline holds pure datapath values qualified by the FSM, so it
    // carries no reset; only control state and visible outputs are reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mul_pipe[0] <= w_product;
        end
        for (int i = 1; i < MUL_STAGES; i++) begin
            r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Divider sign handling: divide magnitudes, then restore signs.
    // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(XLEN-1).
    // ------------------------------------------------------------------
    assign w_a_neg       = ~r_unsigned & r_a[XLEN-1];
    assign w_b_neg       = ~r_unsigned & r_b[XLEN-1];
    assign w_abs_a       = w_a_neg ? -r_a : r_a;
    assign w_abs_b       = w_b_neg ? -r_b : r_b;
    assign w_div_by_zero = (r_b == '0);
    assign w_div_start   = (r_state == ST_DIV_PREP) && !flush && !w_div_by_zero;
    assign w_quo_fix     = r_q_neg ? -w_quo : w_quo;
    assign w_rem_fix     = r_r_neg ? -w_rem : w_rem;

    muldiv_divider #(
        .XLEN (XLEN)
    ) u_divider (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_abort     (flush),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_div_done)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != ST_IDLE);
        opreat_over  = (r_state == ST_DONE);
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (op[2]) begin
`ifdef MULDIV_ACC_EN
                            w_next_state = ST_MUL;
`else
                            w_next_state = ST_DONE;
`endif
                        end else if (op[1]) begin
                            w_next_state = ST_DIV_PREP;
                        end else begin
                            w_next_state = ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) begin
`ifdef MULDIV_ACC_EN
                        w_next_state = r_acc ? ST_ACC : ST_DONE;
`else
                        w_next_state = ST_DONE;
`endif
                    end
                end
`ifdef MULDIV_ACC_EN
                ST_ACC:      w_next_state = ST_DONE;
`endif
                ST_DIV_PREP: w_next_state = w_div_by_zero ? ST_DONE : ST_DIV_ITER;
                ST_DIV_ITER: if (w_div_done) w_next_state = ST_DIV_FIX;
                ST_DIV_FIX:  w_next_state = ST_DONE;
                ST_DONE:     if (!is_busbusy) w_next_state = ST_IDLE;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand capture and result register. r_result only changes on the
    // way into DONE, so the outputs stay stable for the whole DONE hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_unsigned <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_mul_cnt  <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
`ifdef MULDIV_ACC_EN
            r_acc      <= 1'b0;
            r_sub      <= 1'b0;
            r_hilo_in  <= '0;
`endif
        end else if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_unsigned <= op[0];
                        r_a        <= opreat_A;
                        r_b        <= opreat_B;
                        r_mul_cnt  <= '0;
`ifdef MULDIV_ACC_EN
                        r_acc      <= op[2];
                        r_sub      <= op[1];
                        r_hilo_in  <= hi_lo_in;
`else
                        if (op[2]) begin
                            r_result <= hi_lo_in;
                        end
`endif
                    end
                end
                ST_MUL: begin
                    r_mul_cnt <= r_mul_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_result <= r_mul_pipe[MUL_STAGES-1];
                    end
                end
`ifdef MULDIV_ACC_EN
                ST_ACC: begin
                    r_result <= r_sub ? (r_hilo_in - r_result) : (r_hilo_in + r_result);
                end
`endif
                ST_DIV_PREP: begin
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    if (w_div_by_zero) begin
                        r_result <= {r_a, {XLEN{1'b1}}};
                    end
                end
                ST_DIV_FIX: begin
                    r_result <= {w_rem_fix, w_quo_fix};
                end
                default: ;
            endcase
        end
    end

    assign hi_value = r_result[2*XLEN-1:XLEN];
    assign lo_value = r_result[XLEN-1:0];

endmodule

// File: tb/tb_ex_muldiv.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv
// Self-checking bench for ex_muldiv (XLEN=32, MUL_STAGES=2). Directed cases
// followed by random operations, each compared against a plain-arithmetic
// reference of the {HI,LO} result and the completion latency.
// Honours MULDIV_ACC_EN for the expected behaviour of ops 100-111.
// -----------------------------------------------------------------------------
module tb_ex_muldiv;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        op;
    logic [XLEN-1:0]   opreat_A;
    logic [XLEN-1:0]   opreat_B;
    logic [2*XLEN-1:0] hi_lo_in;
    logic              is_busbusy;
    logic              flush;
    logic              busy;
    logic              opreat_over;
    logic [XLEN-1:0]   hi_value;
    logic [XLEN-1:0]   lo_value;

    int checks   = 0;
    int failures = 0;

    ex_muldiv #(
        .XLEN       (XLEN),
        .MUL_STAGES (MUL_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .opreat_A    (opreat_A),
        .opreat_B    (opreat_B),
        .hi_lo_in    (hi_lo_in),
        .is_busbusy  (is_busbusy),
        .flush       (flush),
        .busy        (busy),
        .opreat_over (opreat_over),
        .hi_value    (hi_value),
        .lo_value    (lo_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {HI,LO} computed from the arithmetic definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o[0]) p = {32'b0, a} * {32'b0, b};
        else      p = sa * sb;
        case (o)
            3'b000, 3'b001: return p;
            3'b010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
`ifdef MULDIV_ACC_EN
                return o[1] ? (hl - p) : (hl + p);
`else
                return hl;
`endif
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] b);
        if (o[2]) begin
`ifdef MULDIV_ACC_EN
            return MUL_STAGES + 2;
`else
            return 1;
`endif
        end
        if (o[1]) return (b == 0) ? 2 : XLEN + 3;
        return MUL_STAGES + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF & $urandom;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle. Launches one operation,
    // scrambles the inputs afterwards, and checks latency, result and the
    // return to idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hl, input string tag);
        logic [63:0] exp;
        int          exp_lat;
        int          lat;
        exp     = model(o, a, b, hl);
        exp_lat = model_lat(o, b);
        start    = 1'b1;
        op       = o;
        opreat_A = a;
        opreat_B = b;
        hi_lo_in = hl;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        op       = 3'($urandom);
        opreat_A = $urandom;
        opreat_B = $urandom;
        hi_lo_in = {$urandom, $urandom};
        check({tag, "_busy1"}, 64'(busy), 64'd1);
        lat = 1;
        while (!opreat_over && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, 64'(hi_value), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(lo_value), 64'(exp[31:0]));
        @(negedge clk);
        check({tag, "_over_off"}, 64'(opreat_over), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] hl;
        int          lat;
        int          over_cycles;
        logic        stable;
        logic        seen_over;

        reset      = 1'b1;
        start      = 1'b0;
        op         = 3'b000;
        opreat_A   = '0;
        opreat_B   = '0;
        hi_lo_in   = '0;
        is_busbusy = 1'b0;
        flush      = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_over", 64'(opreat_over), 64'd0);
        check("rst_hi", 64'(hi_value), 64'd0);
        check("rst_lo", 64'(lo_value), 64'd0);

        // Directed operations (back-to-back: each starts in the first idle cycle)
        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 64'd0, "mult_m2x3");
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, "multu_max");
        run_op(3'b011, 32'd100, 32'd7, 64'd0, "divu_100_7");
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, "div_m7_2");
        run_op(3'b010, 32'h0000_1234, 32'd0, 64'd0, "div_by0");
        run_op(3'b011, 32'hDEAD_BEEF, 32'd0, 64'd0, "divu_by0");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, "div_min_m1");
        run_op(3'b100, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF, "madd_carry");
        run_op(3'b110, 32'hFFFF_FFFF, 32'd2, 64'h0000_0000_0000_0005, "msub_neg");
        run_op(3'b111, 32'hFFFF_FFFF, 32'd2, 64'h0000_0000_0000_0005, "msubu_wrap");

        // Flush during divu at cycle 10, then a new mult in cycle 11
        start    = 1'b1;
        op       = 3'b011;
        opreat_A = 32'd1000;
        opreat_B = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        seen_over = 1'b0;
        for (int c = 1; c < 10; c++) begin
            seen_over |= opreat_over;
            @(negedge clk);
        end
        seen_over |= opreat_over;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_no_over", 64'(seen_over | opreat_over), 64'd0);
        run_op(3'b000, 32'd6, 32'd7, 64'd0, "mult_after_flush");

        // Downstream hold for 5 cycles in DONE, with a start pulse that must be ignored
        is_busbusy = 1'b1;
        start      = 1'b1;
        op         = 3'b000;
        opreat_A   = 32'd5;
        opreat_B   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!opreat_over && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_lat", 64'(lat), 64'(MUL_STAGES + 1));
        over_cycles = 0;
        stable      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (opreat_over) over_cycles++;
            stable &= (hi_value === 32'd0) && (lo_value === 32'd35);
            if (c == 2) begin
                start    = 1'b1;
                op       = 3'b010;
                opreat_A = 32'd9;
                opreat_B = 32'd3;
            end
            if (c == 3) start = 1'b0;
            if (c == 5) is_busbusy = 1'b0;
            @(negedge clk);
        end
        check("hold_over_cycles", 64'(over_cycles), 64'd6);
        check("hold_stable", 64'(stable), 64'd1);
        check("hold_release_over", 64'(opreat_over), 64'd0);
        check("hold_start_ignored", 64'(busy), 64'd0);

        // Asynchronous reset mid-divide, then immediate restart
        start    = 1'b1;
        op       = 3'b011;
        opreat_A = 32'd77;
        opreat_B = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi_value), 64'd0);
        check("arst_lo", 64'(lo_value), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'b001, 32'd12, 32'd11, 64'd0, "mult_after_rst");

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            hl = {$urandom, $urandom};
            run_op(3'($urandom_range(0, 7)), pick(), pick(), hl, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
